// File: rtl/timer_ctrl.sv
// Prescaled down-counting timer with start/pause/abort control.
// Define TIMER_CTRL_AUTORELOAD_EN for periodic reload on expiry.
module timer_ctrl #(
    parameter int DIV   = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             load_valid,
    input  logic [CNT_W-1:0] load_value,
    output logic             load_ready,
    output logic             tick_out,
    output logic             expired,
    output logic             busy,
    output logic [CNT_W-1:0] count
);
    localparam int PSC_W = $clog2(DIV);
    localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nx;
    logic [PSC_W-1:0] r_psc;
    logic [PSC_W-1:0] w_psc_nx;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nx;
    logic [CNT_W-1:0] r_reload;
    logic [CNT_W-1:0] w_reload_nx;
    logic             r_tick;
    logic             w_tick_nx;
    logic             r_expired;
    logic             w_expired_nx;
    logic             r_busy;
    logic             r_load_ready;
    logic             w_ready_nx;
    logic             w_load;
    logic             w_go;

    assign w_load = load_valid && r_load_ready;
    // stop always wins over a simultaneous start
    assign w_go   = start && !stop;

    always_comb begin
        w_state_nx   = r_state;
        w_psc_nx     = r_psc;
        w_count_nx   = r_count;
        w_reload_nx  = w_load ? load_value : r_reload;
        w_tick_nx    = 1'b0;
        w_expired_nx = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_go && (r_reload != '0)) begin
                    w_state_nx = S_RUN;
                    w_count_nx = r_reload;
                    w_psc_nx   = '0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_state_nx = S_PAUSE;
                end else if (r_psc == PSC_MAX) begin
                    w_psc_nx  = '0;
                    w_tick_nx = 1'b1;
                    if (r_count != '0)
                        w_count_nx = r_count - CNT_W'(1);
                    if (r_count == CNT_W'(1)) begin
                        w_expired_nx = 1'b1;
`ifdef TIMER_CTRL_AUTORELOAD_EN
                        // a zero reload cannot start a new period
                        if (r_reload != '0)
                            w_count_nx = r_reload;
                        else
                            w_state_nx = S_DONE;
`else
                        w_state_nx = S_DONE;
`endif
                    end
                end else begin
                    w_psc_nx = r_psc + PSC_W'(1);
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    w_state_nx = S_IDLE;
                    w_count_nx = '0;
                    w_psc_nx   = '0;
                end else if (start) begin
                    w_state_nx = S_RUN;
                end
            end
        endcase
    end

`ifdef TIMER_CTRL_AUTORELOAD_EN
    assign w_ready_nx = (w_state_nx != S_PAUSE);
`else
    assign w_ready_nx = (w_state_nx == S_IDLE) || (w_state_nx == S_DONE);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_psc        <= '0;
            r_count      <= '0;
            r_reload     <= '0;
            r_tick       <= 1'b0;
            r_expired    <= 1'b0;
            r_busy       <= 1'b0;
            r_load_ready <= 1'b1;
        end else begin
            r_state      <= w_state_nx;
            r_psc        <= w_psc_nx;
            r_count      <= w_count_nx;
            r_reload     <= w_reload_nx;
            r_tick       <= w_tick_nx;
            r_expired    <= w_expired_nx;
            r_busy       <= (w_state_nx == S_RUN) || (w_state_nx == S_PAUSE);
            r_load_ready <= w_ready_nx;
        end
    end

    assign load_ready = r_load_ready;
    assign tick_out   = r_tick;
    assign expired    = r_expired;
    assign busy       = r_busy;
    assign count      = r_count;
endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with a pulse-timing scoreboard.
// Build with TIMER_CTRL_AUTORELOAD_EN to exercise periodic mode.
module tb_timer_ctrl;
    localparam int DIV   = 6;
    localparam int CNT_W = 16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             load_valid = 1'b0;
    logic [CNT_W-1:0] load_value = '0;
    logic             load_ready;
    logic             tick_out;
    logic             expired;
    logic             busy;
    logic [CNT_W-1:0] count;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int e0       = 0;
    int q_tick[$];
    int q_exp[$];

    timer_ctrl #(.DIV(DIV), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .load_valid (load_valid),
        .load_value (load_value),
        .load_ready (load_ready),
        .tick_out   (tick_out),
        .expired    (expired),
        .busy       (busy),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One active edge; pulses are matched against the expected-edge queues.
    task automatic step();
        bit want_t;
        bit want_e;
        @(posedge clk);
        cyc++;
        #1;
        want_t = (q_tick.size() > 0) && (q_tick[0] == cyc);
        want_e = (q_exp.size() > 0) && (q_exp[0] == cyc);
        if (want_t) void'(q_tick.pop_front());
        if (want_e) void'(q_exp.pop_front());
        chk($sformatf("tick_out@%0d", cyc), 32'(tick_out), 32'(want_t));
        chk($sformatf("expired@%0d", cyc), 32'(expired), 32'(want_e));
    endtask

    task automatic expect_run(input int base, input int n);
        for (int k = 1; k <= n; k++) q_tick.push_back(base + k * DIV);
        q_exp.push_back(base + n * DIV);
    endtask

    task automatic do_load(input int v);
        load_valid = 1'b1;
        load_value = CNT_W'(v);
        step();
        load_valid = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk("rst_tick", 32'(tick_out), 0);
        chk("rst_expired", 32'(expired), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_load_ready", 32'(load_ready), 1);
        chk("rst_state", 32'(dut.r_state), 32'(S_IDLE));
        reset = 1'b0;
        step();

`ifdef TIMER_CTRL_AUTORELOAD_EN
        do_load(2);
        start = 1'b1;
        step();
        start = 1'b0;
        e0 = cyc;
        for (int k = 1; k <= 6; k++) q_tick.push_back(e0 + k * DIV);
        q_exp.push_back(e0 + 12);
        q_exp.push_back(e0 + 24);
        q_exp.push_back(e0 + 36);
        chk("ar_ready_run", 32'(load_ready), 1);
        repeat (37) begin
            step();
            chk("ar_busy", 32'(busy), 1);
        end
        chk("ar_state", 32'(dut.r_state), 32'(S_RUN));
        stop = 1'b1;
        step();
        step();
        stop = 1'b0;
        chk("ar_abort_state", 32'(dut.r_state), 32'(S_IDLE));
        chk("ar_abort_count", 32'(count), 0);
`else
        start = 1'b1;
        step();
        start = 1'b0;
        chk("zero_reload_state", 32'(dut.r_state), 32'(S_IDLE));
        chk("zero_reload_busy", 32'(busy), 0);
        repeat (3) step();

        do_load(3);
        chk("reload3", 32'(dut.r_reload), 3);
        start = 1'b1;
        step();
        start = 1'b0;
        e0 = cyc;
        expect_run(e0, 3);
        chk("run3_count", 32'(count), 3);
        chk("run3_busy", 32'(busy), 1);
        chk("run3_ready", 32'(load_ready), 0);
        repeat (20) step();
        chk("done_state", 32'(dut.r_state), 32'(S_DONE));
        chk("done_count", 32'(count), 0);
        chk("done_busy", 32'(busy), 0);
        chk("done_ready", 32'(load_ready), 1);

        load_valid = 1'b1;
        load_value = CNT_W'(4);
        start = 1'b1;
        step();
        load_valid = 1'b0;
        start = 1'b0;
        e0 = cyc;
        expect_run(e0, 3);
        chk("ldst_count_old", 32'(count), 3);
        chk("ldst_reload_new", 32'(dut.r_reload), 4);
        repeat (20) step();
        chk("ldst_done", 32'(dut.r_state), 32'(S_DONE));

        start = 1'b1;
        step();
        start = 1'b0;
        e0 = cyc;
        q_tick.push_back(e0 + 6);
        repeat (7) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("pause_state", 32'(dut.r_state), 32'(S_PAUSE));
        chk("pause_busy", 32'(busy), 1);
        repeat (9) begin
            step();
            chk("pause_count", 32'(count), 3);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        e0 = cyc;
        q_tick.push_back(e0 + 5);
        q_tick.push_back(e0 + 11);
        q_tick.push_back(e0 + 17);
        q_exp.push_back(e0 + 17);
        chk("resume_state", 32'(dut.r_state), 32'(S_RUN));
        repeat (20) step();
        chk("resume_done", 32'(dut.r_state), 32'(S_DONE));

        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        chk("both_pause", 32'(dut.r_state), 32'(S_PAUSE));
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("abort_state", 32'(dut.r_state), 32'(S_IDLE));
        chk("abort_count", 32'(count), 0);
        chk("abort_busy", 32'(busy), 0);
        repeat (30) step();

        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("run_ready_low", 32'(load_ready), 0);
        do_load(9);
        chk("run_reload_kept", 32'(dut.r_reload), 4);
        stop = 1'b1;
        step();
        step();
        stop = 1'b0;
        chk("run_load_abort", 32'(dut.r_state), 32'(S_IDLE));

        do_load(5);
        start = 1'b1;
        step();
        start = 1'b0;
        e0 = cyc;
        q_tick.push_back(e0 + 6);
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_tick", 32'(tick_out), 0);
        chk("mid_rst_expired", 32'(expired), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_ready", 32'(load_ready), 1);
        chk("mid_rst_state", 32'(dut.r_state), 32'(S_IDLE));
        chk("mid_rst_reload", 32'(dut.r_reload), 0);
        repeat (40) step();
`endif

        chk("tick_queue_drained", q_tick.size(), 0);
        chk("exp_queue_drained", q_exp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
